rs_add_scheduler: RTL
=====================

Name: rs_add_scheduler

Overview:
- Wakeup/select controller for the 4-entry add/sub reservation station of the Tomasulo core.
- Tracks per-entry lifecycle (FREE/WAIT/READY/ISSUED) and operand readiness by snooping the CDB.
- Issues the oldest ready entry to the single add/sub functional unit through a valid/ready handshake, and frees the entry on FU completion.
- Operand values, opcode and PC stay in the RS storage arrays; this block returns entry indices and the destination ROB tag only.

Parameters:
- N_ENT, 4, number of RS entries (power of 2).
- IDX_W, 2, log2(N_ENT).
- TAG_W, 3, ROB tag width (8-entry ROB).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all entries.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_ready  out  1  at least one FREE entry.
- alloc_idx  out  IDX_W  entry granted (lowest-index FREE).
- alloc_s1_valid  in  1  source 1 value already available.
- alloc_s1_tag  in  TAG_W  source 1 producer ROB tag.
- alloc_s2_valid  in  1  source 2 value already available.
- alloc_s2_tag  in  TAG_W  source 2 producer ROB tag.
- alloc_dest_tag  in  TAG_W  destination ROB tag.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  broadcast ROB tag.
- issue_valid  out  1  a READY entry is offered to the FU.
- issue_ready  in  1  FU accepts.
- issue_idx  out  IDX_W  selected entry.
- issue_dest_tag  out  TAG_W  dest tag of selected entry.
- done_valid  in  1  FU finished the op for an entry.
- done_idx  in  IDX_W  entry to free.
- s1_wake  out  N_ENT  per-entry strobe: RS must latch the CDB value into S1 this cycle.
- s2_wake  out  N_ENT  per-entry strobe: RS must latch the CDB value into S2 this cycle.
- occupancy  out  IDX_W+1  count of non-FREE entries.

Behaviour:
- Reset or flush:
  - All entries go to FREE next cycle; age state is cleared.
  - occupancy=0, issue_valid=0, s1_wake/s2_wake=0.
  - flush overrides alloc, wake, issue and done in the same cycle.
- Per-entry state:
  - FREE → WAIT or READY on allocation.
  - WAIT → READY once both sources are valid.
  - READY → ISSUED on an issue handshake.
  - ISSUED → FREE on done_valid with matching done_idx.
  - A done_valid for an entry that is not ISSUED is ignored; the bench flags it as an error.
- Allocation:
  - Fires when alloc_valid && alloc_ready.
  - Takes the lowest-index FREE entry; alloc_idx is combinational from the registered state.
  - An entry freed by done in cycle t is allocatable from t+1.
- Same-cycle bypass: an alloc source with valid=0 whose tag equals cdb_tag while cdb_valid=1 is stored as valid.
  - No wake strobe is raised for that entry; the RS captures the CDB value on the alloc path.
- Wakeup:
  - For each WAIT entry, an invalid source whose tag matches a valid CDB tag becomes valid next cycle.
  - The matching s1_wake/s2_wake bit is asserted combinationally in the same cycle.
  - One broadcast may wake several entries and both sources of one entry.
- Readiness: an entry becomes READY in the cycle after its last source becomes valid, so issue_valid can first assert at t+1.
  - Alloc with both sources valid at t → issue offered at t+1.
  - CDB match at t → issue offered at t+1.
- Select:
  - issue_valid = any READY entry.
  - issue_idx = the oldest READY entry by allocation order.
  - Order is tracked by an N×N age matrix set on alloc and cleared on free.
  - issue_idx and issue_dest_tag are held stable while issue_valid && !issue_ready.
  - The selection may change only if an older entry becomes READY.
- Simultaneous events in one cycle (alloc, wake, issue, done on distinct entries) are all applied; none blocks another.
- occupancy:
  - Increments on alloc, decrements on done.
  - Unchanged when both happen in the same cycle.
  - Never exceeds N_ENT.

Decomposition:
- Shared package tomasulo_pkg:
  - ROB tag width TAG_W and RS index width.
  - Entry state enum {FREE, WAIT, READY, ISSUED}.
  - Tag and index typedefs.
- One sub-module, age_matrix_select:
  - Inputs: N_ENT request vector, alloc/free strobes.
  - Output: one-hot oldest grant.

Test Plan:
- Reset then alloc dest=1, s1/s2 valid → alloc_idx=0; issue_valid=1 with issue_idx=0 and issue_dest_tag=1 one cycle later; occupancy=1.
- Alloc idx0 with s1_tag=3 invalid; cdb_valid=1, cdb_tag=3 two cycles later → s1_wake=4'b0001 that cycle, issue_valid=1 next cycle.
- Alloc 4 entries with ready operands, issue_ready=0 → alloc_ready=0, issue_idx=0 held stable; issue_ready=1 → issued in order 0,1,2,3.
- Alloc entry0 with s2_tag=5 waiting, entry1 ready, then CDB tag 5 → entry1 issues first; entry0 then wins over any later-allocated READY entry.
- Alloc with s1_tag=6 invalid while cdb_tag=6 valid in the same cycle → no wake strobe; issue offered next cycle.
- Flush with 3 busy entries, plus alloc and done the same cycle → next cycle occupancy=0, alloc_ready=1, alloc_idx=0, issue_valid=0.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths, tag/index types and RS entry lifecycle states
package tomasulo_pkg;
  localparam int N_ENT = 4;
  localparam int IDX_W = 2;
  localparam int TAG_W = 3;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {FREE, WAIT, READY, ISSUED} ent_st_e;
endpackage

// File: rtl/age_matrix_select.sv
// age_matrix_select: allocation-order age matrix granting the oldest requester
module age_matrix_select #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] alloc_i,
  input  logic [N-1:0] free_i,
  output logic [N-1:0] grant_o
);
  logic [N-1:0] vld_q, vld_d;
  logic [N-1:0] old_q [N];
  logic [N-1:0] old_d [N];
  // row i marks entries older than i; a new entry inherits every live entry as older
  always_comb begin
    vld_d = (vld_q & ~free_i) | alloc_i;
    grant_o = '0;
    for (int i = 0; i < N; i++) begin
      old_d[i] = alloc_i[i] ? (vld_q & ~free_i) : (old_q[i] & ~free_i & ~alloc_i);
      grant_o[i] = req_i[i] && !(|(old_q[i] & req_i));
    end
  end
  // age state register
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < N; i++) old_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      old_q <= old_d;
    end
  end
endmodule

// File: rtl/rs_add_scheduler.sv
// rs_add_scheduler: wakeup/select control for the 4-entry add/sub reservation station
module rs_add_scheduler
  import tomasulo_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output idx_t             alloc_idx,
  input  logic             alloc_s1_valid,
  input  tag_t             alloc_s1_tag,
  input  logic             alloc_s2_valid,
  input  tag_t             alloc_s2_tag,
  input  tag_t             alloc_dest_tag,
  input  logic             cdb_valid,
  input  tag_t             cdb_tag,
  output logic             issue_valid,
  input  logic             issue_ready,
  output idx_t             issue_idx,
  output tag_t             issue_dest_tag,
  input  logic             done_valid,
  input  idx_t             done_idx,
  output logic [N_ENT-1:0] s1_wake,
  output logic [N_ENT-1:0] s2_wake,
  output logic [IDX_W:0]   occupancy
);
  ent_st_e st_q [N_ENT];
  ent_st_e st_d [N_ENT];
  logic [N_ENT-1:0] s1v_q, s1v_d, s2v_q, s2v_d;
  tag_t s1t_q [N_ENT];
  tag_t s1t_d [N_ENT];
  tag_t s2t_q [N_ENT];
  tag_t s2t_d [N_ENT];
  tag_t dst_q [N_ENT];
  tag_t dst_d [N_ENT];
  logic [N_ENT-1:0] free_v, rdy_v, grant, alloc_oh, issue_oh, done_oh, age_free;
  logic alloc_fire, issue_fire, done_ok, a_s1v, a_s2v;
  // decode registered state into free/ready masks, pick entries, raise wake strobes
  always_comb begin
    free_v = '0;
    rdy_v = '0;
    occupancy = '0;
    alloc_idx = '0;
    issue_idx = '0;
    s1_wake = '0;
    s2_wake = '0;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      free_v[i] = st_q[i] == FREE;
      rdy_v[i] = st_q[i] == READY;
      occupancy = occupancy + (IDX_W + 1)'(st_q[i] != FREE);
      alloc_idx = free_v[i] ? idx_t'(i) : alloc_idx;
      issue_idx = grant[i] ? idx_t'(i) : issue_idx;
      s1_wake[i] = cdb_valid && !flush && st_q[i] == WAIT && !s1v_q[i] && s1t_q[i] == cdb_tag;
      s2_wake[i] = cdb_valid && !flush && st_q[i] == WAIT && !s2v_q[i] && s2t_q[i] == cdb_tag;
    end
  end
  assign alloc_ready = |free_v;
  assign issue_valid = |rdy_v && !flush;
  assign issue_dest_tag = dst_q[issue_idx];
  assign alloc_fire = alloc_valid && alloc_ready && !flush;
  assign issue_fire = issue_valid && issue_ready;
  assign done_ok = done_valid && !flush && st_q[done_idx] == ISSUED;
  assign alloc_oh = alloc_fire ? N_ENT'(1) << alloc_idx : '0;
  assign issue_oh = issue_fire ? grant : '0;
  assign done_oh = done_ok ? N_ENT'(1) << done_idx : '0;
  assign age_free = flush ? '1 : done_oh;
  assign a_s1v = alloc_s1_valid || (cdb_valid && alloc_s1_tag == cdb_tag);
  assign a_s2v = alloc_s2_valid || (cdb_valid && alloc_s2_tag == cdb_tag);
  // per-entry lifecycle: alloc, wakeup, issue and done all applied in parallel; flush wins
  always_comb begin
    for (int i = 0; i < N_ENT; i++) begin
      st_d[i] = st_q[i];
      s1v_d[i] = s1v_q[i];
      s2v_d[i] = s2v_q[i];
      s1t_d[i] = s1t_q[i];
      s2t_d[i] = s2t_q[i];
      dst_d[i] = dst_q[i];
      if (alloc_oh[i]) begin
        st_d[i] = (a_s1v && a_s2v) ? READY : WAIT;
        s1v_d[i] = a_s1v;
        s2v_d[i] = a_s2v;
        s1t_d[i] = alloc_s1_tag;
        s2t_d[i] = alloc_s2_tag;
        dst_d[i] = alloc_dest_tag;
      end else if (st_q[i] == WAIT) begin
        s1v_d[i] = s1v_q[i] || s1_wake[i];
        s2v_d[i] = s2v_q[i] || s2_wake[i];
        st_d[i] = (s1v_d[i] && s2v_d[i]) ? READY : WAIT;
      end else if (issue_oh[i]) begin
        st_d[i] = ISSUED;
      end else if (done_oh[i]) begin
        st_d[i] = FREE;
      end
      st_d[i] = flush ? FREE : st_d[i];
    end
  end
  // entry state register
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_ENT; i++) st_q[i] <= FREE;
      s1v_q <= '0;
      s2v_q <= '0;
    end else begin
      st_q <= st_d;
      s1v_q <= s1v_d;
      s2v_q <= s2v_d;
    end
  end
  // operand and destination tags need no reset; they are only read for live entries
  always_ff @(posedge clk) begin
    s1t_q <= s1t_d;
    s2t_q <= s2t_d;
    dst_q <= dst_d;
  end
  age_matrix_select #(.N(N_ENT)) u_age (
    .clk     (clk),
    .reset   (reset),
    .req_i   (rdy_v),
    .alloc_i (alloc_oh),
    .free_i  (age_free),
    .grant_o (grant)
  );
endmodule
